alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALUop, IsShamt flag and register operands produced by the ALU decoder.
- Simple ops complete in one cycle.
- MUL/DIV run iteratively over 32 cycles.
- A valid/ready handshake on both sides lets the pipeline stall on the multi-cycle ops; the result is held until the downstream writeback stage accepts it.

Parameters:
- WIDTH, 32, datapath width; shift amount is log2(WIDTH) bits.
- ITERS, 32, MUL/DIV iteration count; must equal WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and alu_op are valid this cycle.
- in_ready  output  1  block can accept a new operation.
- alu_op  input  4  0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT, 12 SLTU, 13-15 reserved.
- is_shamt  input  1  shift amount comes from shamt, not from a[4:0].
- shamt  input  5  instruction shift-amount field.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand; this is the value shifted.
- out_valid  output  1  result/result_hi are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  primary result; LO for MUL, quotient for DIV.
- result_hi  output  WIDTH  HI for MUL, remainder for DIV, 0 otherwise.
- zero  output  1  result == 0, registered with result.
- busy  output  1  FSM is in BUSY.

Behaviour:
- States and reset
  - States: IDLE, BUSY, DONE.
  - rst: state=IDLE, out_valid=0, result=0, result_hi=0, zero=1, busy=0, iteration counter=0.
  - rst mid-operation aborts immediately with no output.
- Input handshake
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept happens when in_valid && in_ready.
  - A DONE-state accept with out_ready=1 retires the old result and starts the new op in the same cycle, so back-to-back throughput is 1 op/cycle for simple ops.
- Op routing and latency
  - Simple ops (0-2, 5-12): result registered at the accept edge; state goes to DONE; out_valid=1 on the next cycle (latency 1).
  - Ops 3/4: latch operands; counter=0; state goes to BUSY.
  - In BUSY, one iteration per cycle; after ITERS iterations state goes to DONE (out_valid 33 cycles after accept). in_ready=0 throughout BUSY.
- Output handshake
  - In DONE, outputs are held stable until out_ready=1.
  - out_ready=1 with no new accept: state goes to IDLE, out_valid=0.
- Shifts
  - Amount = is_shamt ? shamt : a[4:0].
  - SRA sign-fills from b[31].
  - Amount 0 passes b unchanged.
- Arithmetic
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is signed; SLTU is unsigned; both return 0 or 1.
- MUL
  - Unsigned shift-add.
  - {result_hi,result} = a*b (64-bit).
- DIV
  - Unsigned restoring division: result=a/b, result_hi=a%b.
  - b==0: result=32'hFFFFFFFF, result_hi=a; still takes the full ITERS cycles.
- Reserved codes 13-15: result=0, result_hi=0, latency 1.
- in_valid while in_ready=0 is ignored; upstream must hold its inputs.

Optional Feature:
- Macro ALU_SIGNED_MULDIV_EN.
- Defined:
  - MUL/DIV treat a and b as two's-complement: operands are converted to magnitude, iterated, then sign-corrected.
  - Remainder takes the sign of the dividend.
  - 32'h80000000 / 32'hFFFFFFFF gives result=32'h80000000, result_hi=0.
  - b==0 behaviour is unchanged.
- Undefined: MUL/DIV are unsigned only, as in Behaviour.

Test Plan:
- rst held 2 cycles, then ADD a=7 b=5, out_ready=1 -> next cycle out_valid=1, result=12, zero=0; following cycle out_valid=0.
- Shifts with b=32'h80000000: SRA is_shamt=1 shamt=4 -> result=32'hF8000000; SRL a=4 is_shamt=0 -> result=32'h08000000; SLL shamt=0 -> 32'h80000000.
- MUL a=32'hFFFFFFFF b=2 -> in_ready=0 and busy=1 for 32 cycles, then result=32'hFFFFFFFE, result_hi=1.
- DIV a=100 b=7 -> result=14, result_hi=2; DIV a=5 b=0 -> result=32'hFFFFFFFF, result_hi=5.
- Backpressure: SUB a=3 b=3 with out_ready=0 for 5 cycles -> result=0, zero=1, outputs stable, in_ready=0; raise out_ready with a new in_valid ADD 1+1 -> accepted that cycle, result=2 next cycle.
- Reset mid-DIV (rst asserted at iteration 10) -> next cycle state IDLE, out_valid=0, in_ready=1, no stale result is ever presented.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle simple ops, 32-iteration shift-add MUL and restoring DIV,
// valid/ready on both sides. Define ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               alu_op,
  input  logic                     is_shamt,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         result_hi,
  output logic                     zero,
  output logic                     busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, mcand_reg;
  logic             is_div_reg, neg_lo_reg, neg_hi_reg;
  logic             out_valid_reg, zero_reg, busy_reg;
  logic [WIDTH-1:0] result_reg, result_hi_reg;

  logic             accept, is_muldiv;
  logic [SW-1:0]    shift_amt;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             load_neg_lo, load_neg_hi;
  logic [WIDTH:0]   mul_sum;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

  assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_muldiv = (alu_op == OP_MUL) || (alu_op == OP_DIV);

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign busy      = busy_reg;

  always_comb begin
    shift_amt  = is_shamt ? shamt : a[SW-1:0];
    simple_res = '0;
    case (alu_op)
      OP_SLL:  simple_res = b << shift_amt;
      OP_SRA:  simple_res = $signed(b) >>> shift_amt;
      OP_SRL:  simple_res = b >> shift_amt;
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_XOR:  simple_res = a ^ b;
      OP_NOR:  simple_res = ~(a | b);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: simple_res = '0;
    endcase
  end

  // Operands are iterated as magnitudes; sign flags restore the result at the end.
`ifdef ALU_SIGNED_MULDIV_EN
  assign a_mag       = a[WIDTH-1] ? -a : a;
  assign b_mag       = b[WIDTH-1] ? -b : b;
  assign load_neg_lo = (alu_op == OP_DIV) ? ((a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0))
                                          : (a[WIDTH-1] ^ b[WIDTH-1]);
  assign load_neg_hi = (alu_op == OP_DIV) && a[WIDTH-1];
`else
  assign a_mag       = a;
  assign b_mag       = b;
  assign load_neg_lo = 1'b0;
  assign load_neg_hi = 1'b0;
`endif

  // One iteration: MUL shifts {hi,lo} right adding the multiplicand; DIV shifts the
  // dividend out of lo into hi and subtracts the divisor when it fits.
  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
    div_ge  = ({hi_reg, lo_reg[WIDTH-1]} >= {1'b0, mcand_reg});
    if (is_div_reg) begin
      if (div_ge) begin
        step_hi = WIDTH'({hi_reg, lo_reg[WIDTH-1]} - {1'b0, mcand_reg});
        step_lo = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
        step_lo = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    fin_hi = step_hi;
    fin_lo = step_lo;
    if (is_div_reg) begin
      if (neg_lo_reg) fin_lo = -step_lo;
      if (neg_hi_reg) fin_hi = -step_hi;
    end else if (neg_lo_reg) begin
      {fin_hi, fin_lo} = -{step_hi, step_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      mcand_reg     <= '0;
      is_div_reg    <= 1'b0;
      neg_lo_reg    <= 1'b0;
      neg_hi_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (is_muldiv) begin
              is_div_reg    <= (alu_op == OP_DIV);
              neg_lo_reg    <= load_neg_lo;
              neg_hi_reg    <= load_neg_hi;
              hi_reg        <= '0;
              lo_reg        <= (alu_op == OP_DIV) ? a_mag : b_mag;
              mcand_reg     <= (alu_op == OP_DIV) ? b_mag : a_mag;
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= BUSY;
            end else begin
              result_reg    <= simple_res;
              result_hi_reg <= '0;
              zero_reg      <= (simple_res == '0);
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end else if (state_reg == DONE && out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        BUSY: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(ITERS - 1)) begin
            result_reg    <= fin_lo;
            result_hi_reg <= fin_hi;
            zero_reg      <= (fin_lo == '0);
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: reset, simple ops, shifts, MUL/DIV, backpressure, mid-op reset.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_shamt, out_valid, out_ready, zero, busy;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] a, b, result, result_hi;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_exec #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .is_shamt(is_shamt), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic sh, input logic [4:0] sa);
    alu_op = op; a = av; b = bv; is_shamt = sh; shamt = sa; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("issue op=%0d a=%h b=%h -> out_valid=%b result=%h result_hi=%h",
             op, av, bv, out_valid, result, result_hi);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  int  cyc;
  logic stale;
  logic [31:0] mul_hi_exp;

  initial begin
`ifdef ALU_SIGNED_MULDIV_EN
    mul_hi_exp = 32'hFFFFFFFF;
`else
    mul_hi_exp = 32'h1;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; a = '0; b = '0; is_shamt = 1'b0; shamt = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    issue(4'd5, 32'd7, 32'd5, 1'b0, 5'd0);
    check("add_valid", out_valid, 1);
    check("add_result", result, 12);
    check("add_zero", zero, 0);
    tick();
    check("add_retire", out_valid, 0);

    // Back-to-back simple ops, each accepted while the previous result is retired.
    issue(4'd1, 32'd0, 32'h80000000, 1'b1, 5'd4);
    check("sra", result, 32'hF8000000);
    issue(4'd2, 32'd4, 32'h80000000, 1'b0, 5'd9);
    check("srl", result, 32'h08000000);
    check("srl_valid", out_valid, 1);
    issue(4'd0, 32'd3, 32'h80000000, 1'b1, 5'd0);
    check("sll0", result, 32'h80000000);
    issue(4'd11, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0);
    check("slt", result, 1);
    issue(4'd12, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0);
    check("sltu", result, 0);
    issue(4'd10, 32'd0, 32'd0, 1'b0, 5'd0);
    check("nor", result, 32'hFFFFFFFF);
    issue(4'd6, 32'd0, 32'd1, 1'b0, 5'd0);
    check("sub_wrap", result, 32'hFFFFFFFF);
    issue(4'd13, 32'd9, 32'd9, 1'b0, 5'd0);
    check("rsvd_result", {result_hi, result}, 0);
    check("rsvd_zero", zero, 1);
    tick();
    check("rsvd_retire", out_valid, 0);

    issue(4'd3, 32'hFFFFFFFF, 32'd2, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      check("mul_busy", {busy, in_ready, out_valid}, 3'b100);
      tick();
    end
    check("mul_valid", out_valid, 1);
    check("mul_result", {result_hi, result}, {mul_hi_exp, 32'hFFFFFFFE});
    check("mul_busy_clr", busy, 0);
    $display("mul done result=%h result_hi=%h", result, result_hi);
    tick();
    check("mul_retire", out_valid, 0);

    issue(4'd4, 32'd100, 32'd7, 1'b0, 5'd0);
    wait_done(cyc);
    check("div_latency", cyc, 32);
    check("div_result", {result_hi, result}, {32'd2, 32'd14});
    $display("div done result=%h result_hi=%h", result, result_hi);
    issue(4'd4, 32'd5, 32'd0, 1'b0, 5'd0);
    wait_done(cyc);
    check("div0_latency", cyc, 32);
    check("div0_result", {result_hi, result}, {32'd5, 32'hFFFFFFFF});
    $display("div0 done result=%h result_hi=%h", result, result_hi);
    tick();

    out_ready = 1'b0;
    issue(4'd6, 32'd3, 32'd3, 1'b0, 5'd0);
    alu_op = 4'd5; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {out_valid, zero, in_ready, result}, {3'b110, 32'd0});
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_add", {out_valid, result}, {1'b1, 32'd2});
    $display("backpressure release result=%h", result);
    tick();
    check("bp_retire", out_valid, 0);

    issue(4'd4, 32'd1000, 32'd3, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {out_valid, busy, in_ready}, 3'b001);
    check("abort_result", result, 0);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      tick();
    end
    check("abort_no_stale", stale, 0);
    $display("reset abort checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
